cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmitter end of the common data bus (CDB) writeback interface.
- Collects completed results from the functional units (alu, mult, div, mem). Each unit has its own small queue.
- Round-robin arbitration selects one result per cycle, which is broadcast as a registered wb_bus_t plus its ROB index to the reservation stations, ROB and physical regfile.
- Sits between the execute units and every CDB consumer.

Parameters:
- N_SRC, 4, number of producing functional units. Index 0=alu, 1=mult, 2=div, 3=mem.
- FIFO_DEPTH, 2, entries per source queue; must be a power of two, ≥2.
- PHYS_REG_BITS, 6, physical register index width; taken from the shared package.
- ROB_NUM_BITS, 4, ROB index width; taken from the shared package.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash on branch mispredict.
- src_wb  in  N_SRC x wb_bus_t  per-unit result; .valid is the request.
- src_rob_addr  in  N_SRC x ROB_NUM_BITS  ROB index of each result.
- src_ready  out  N_SRC  per-unit accept.
- cdb  out  wb_bus_t  broadcast result.
- cdb_rob_addr  out  ROB_NUM_BITS  ROB index of the broadcast.

Behaviour:
- Reset (rst_n=0, asynchronous): all queues empty; rr_ptr=0; cdb all-zero (cdb.valid=0); cdb_rob_addr=0. Because the queues are empty, src_ready is all-ones as soon as reset deasserts.
- src_ready[i] = (count[i] != FIFO_DEPTH).
  - Computed from registered state only; a same-cycle pop does not raise ready.
  - Never combinationally dependent on src_wb.
- Push: when src_wb[i].valid && src_ready[i], the packet {wb, rob_addr} is written at the edge. count increments; wr pointer wraps modulo FIFO_DEPTH.
- Arbitration, combinational over queue heads:
  - Winner = first non-empty i scanning rr_ptr, rr_ptr+1, … modulo N_SRC.
  - Winner is popped at the edge and rr_ptr <= (winner+1) mod N_SRC.
  - If all queues are empty, rr_ptr is held.
- Output register:
  - With a winner: cdb <= head.wb with valid forced to 1; cdb_rob_addr <= head.rob_addr.
  - Without a winner: cdb.valid <= 0 and the other fields <= 0.
  - cdb is held for exactly one cycle per result; there is no backpressure from consumers.
- Latency: a push accepted at edge t is broadcast at the earliest in the cycle after edge t+1 (2 cycles). Under contention there is at most N_SRC-1 extra cycles per queue position.
- Simultaneous push and pop on the same queue: both take effect and count is unchanged. A push into a full queue cannot occur.
- rd_addr==0 results are still broadcast (the ROB needs completion); rd_paddr and rd_data pass through unmodified.
- Flush (flush=1 at an edge):
  - All queues emptied; that cycle's pushes discarded; that cycle's pop result discarded.
  - cdb.valid <= 0; rr_ptr held.
  - Flush dominates push and pop.
- Reset mid-operation: queued results are lost and outputs drop immediately to reset values.
- Throughput: one broadcast per cycle when any queue is non-empty. No result is duplicated or reordered within a source.

Decomposition:
- Add to rv32i_types: `typedef struct packed { wb_bus_t wb; logic [ROB_NUM_BITS-1:0] rob_addr; } cdb_pkt_t;`.
- Add a localparam CDB_N_SRC = 4 and source-index constants (CDB_SRC_ALU … CDB_SRC_MEM).
- Sub-module cdb_src_fifo: a single-source FIFO of cdb_pkt_t with push, pop, flush, full, empty and head.
  - Instantiated N_SRC times.
  - The arbiter top holds rr_ptr, the winner select and the output register.

Test Plan:
- Single push: src0 {rd_addr=5, rd_paddr=12, rd_data=0xDEADBEEF, rob=3} at edge 0 → cdb.valid=1 with identical fields and cdb_rob_addr=3 after edge 1 only; cdb.valid=0 the following cycle.
- Fairness: all four sources push one packet at edge 0 (rd_data = 0x10, 0x20, 0x30, 0x40), rr_ptr=0 → broadcasts 0x10, 0x20, 0x30, 0x40 on consecutive cycles; rr_ptr ends at 0.
- Rotation: sources 1 and 3 hold valid continuously → broadcasts alternate 1, 3, 1, 3. src_ready[1] and src_ready[3] drop after queue fill and recover on pop; no packet is lost (scoreboard by rd_data sequence).
- Backpressure/wrap: src2 pushes 6 packets while src0 saturates the bus → src_ready[2]=0 when count=2. All 6 emerge in order, exercising pointer wrap ≥2 times.
- Flush: three queues hold packets and flush=1 for one edge → cdb.valid=0 the next cycle; all src_ready=1; no pre-flush packet ever broadcast; a push in the flush cycle is dropped.
- Async reset: assert rst_n=0 mid-stream between edges → cdb.valid and cdb_rob_addr go to 0 without a clock edge; after release the first broadcast comes only from new pushes.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB writeback arbiter.
//   wb_bus_t  : one functional-unit result as broadcast on the CDB
//   cdb_pkt_t : a queued result plus the ROB index it completes
// Also provides the source-index constants and a round-robin helper.
package cdb_arbiter_pkg;

  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_NUM_BITS  = 4;

  localparam int CDB_N_SRC     = 4;
  localparam int CDB_SRC_ALU   = 0;
  localparam int CDB_SRC_MULT  = 1;
  localparam int CDB_SRC_DIV   = 2;
  localparam int CDB_SRC_MEM   = 3;

  typedef struct packed {
    logic                     valid;
    logic [4:0]               rd_addr;
    logic [PHYS_REG_BITS-1:0] rd_paddr;
    logic [31:0]              rd_data;
  } wb_bus_t;

  typedef struct packed {
    wb_bus_t                 wb;
    logic [ROB_NUM_BITS-1:0] rob_addr;
  } cdb_pkt_t;

  // Next round-robin position after 'idx' among 'n' sources.
  function automatic int unsigned cdb_rr_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Single-source result queue feeding the CDB arbiter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : synchronous squash, empties the queue and drops this cycle's push
//   push_i       : write push_pkt_i (ignored while full)
//   push_pkt_i   : packet to enqueue
//   pop_i        : drop the head entry (ignored while empty)
//   full_o       : queue holds DEPTH entries (registered state only)
//   empty_o      : queue holds no entries
//   head_o       : oldest entry, valid while !empty_o
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  logic     push_i,
  input  cdb_pkt_t push_pkt_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output cdb_pkt_t head_o
);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_pkt_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    do_push_s = push_i & ~full_o;
    do_pop_s  = pop_i & ~empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push in a flush cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {$bits(cdb_pkt_t){1'b0}};
      end
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_pkt_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: per-unit result queues, round-robin pick of one
// head per cycle, registered broadcast to every CDB consumer.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : synchronous squash of all queued and in-flight results
//   src_wb        : per-unit result, .valid is the request
//   src_rob_addr  : ROB index of each unit's result
//   src_ready     : per-unit accept (queue not full, registered state only)
//   cdb           : broadcast result, held one cycle per result
//   cdb_rob_addr  : ROB index of the broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC      = CDB_N_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  wb_bus_t                 src_wb       [N_SRC],
  input  logic [ROB_NUM_BITS-1:0] src_rob_addr [N_SRC],
  output logic [N_SRC-1:0]        src_ready,
  output wb_bus_t                 cdb,
  output logic [ROB_NUM_BITS-1:0] cdb_rob_addr
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]        full_s;
  logic [N_SRC-1:0]        empty_s;
  logic [N_SRC-1:0]        push_s;
  logic [N_SRC-1:0]        pop_s;
  cdb_pkt_t                in_pkt_s [N_SRC];
  cdb_pkt_t                head_s   [N_SRC];

  logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]        winner_s;
  logic [SEL_W-1:0]        idx_s;
  logic                    found_s;
  wb_bus_t                 cdb_q, cdb_d;
  logic [ROB_NUM_BITS-1:0] rob_q, rob_d;

  assign src_ready    = ~full_s;
  assign cdb          = cdb_q;
  assign cdb_rob_addr = rob_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign push_s[g]   = src_wb[g].valid & ~full_s[g];
    assign in_pkt_s[g] = '{wb: src_wb[g], rob_addr: src_rob_addr[g]};

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .push_i     (push_s[g]),
      .push_pkt_i (in_pkt_s[g]),
      .pop_i      (pop_s[g]),
      .full_o     (full_s[g]),
      .empty_o    (empty_s[g]),
      .head_o     (head_s[g])
    );
  end

  // Round-robin winner: first non-empty queue scanning from rr_ptr upward.
  always_comb begin
    found_s  = 1'b0;
    winner_s = SEL_W'(0);
    idx_s    = SEL_W'(0);
    pop_s    = {N_SRC{1'b0}};
    for (int k = 0; k < N_SRC; k++) begin
      idx_s = SEL_W'((int'(rr_ptr_q) + k) % N_SRC);
      if (!found_s && !empty_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
    if (found_s) begin
      pop_s[winner_s] = 1'b1;
    end else begin
      pop_s = {N_SRC{1'b0}};
    end
  end

  // Next pointer and broadcast contents; flush squashes the popped result.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_d    = {$bits(wb_bus_t){1'b0}};
    rob_d    = {ROB_NUM_BITS{1'b0}};
    if (flush) begin
      rr_ptr_d = rr_ptr_q;
    end else if (found_s) begin
      rr_ptr_d       = SEL_W'(cdb_rr_inc(32'(winner_s), 32'(N_SRC)));
      cdb_d          = head_s[winner_s].wb;
      cdb_d.valid    = 1'b1;
      rob_d          = head_s[winner_s].rob_addr;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Arbitration pointer and broadcast output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= SEL_W'(0);
      cdb_q    <= {$bits(wb_bus_t){1'b0}};
      rob_q    <= {ROB_NUM_BITS{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      rob_q    <= rob_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with an expected-broadcast queue.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = CDB_N_SRC;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  wb_bus_t                 src_wb       [N];
  logic [ROB_NUM_BITS-1:0] src_rob_addr [N];
  logic [N-1:0]            src_ready;
  wb_bus_t                 cdb;
  logic [ROB_NUM_BITS-1:0] cdb_rob_addr;

  int       errors = 0;
  int       checks = 0;
  cdb_pkt_t exp_q[$];

  cdb_arbiter #(
    .N_SRC      (N),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .src_wb       (src_wb),
    .src_rob_addr (src_rob_addr),
    .src_ready    (src_ready),
    .cdb          (cdb),
    .cdb_rob_addr (cdb_rob_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cdb_pkt_t mk(input int src, input int n);
    cdb_pkt_t p;
    p.wb.valid    = 1'b1;
    p.wb.rd_addr  = 5'(n + 1);
    p.wb.rd_paddr = 6'(src * 10 + n);
    p.wb.rd_data  = 32'hC0DE_0000 | (32'(src) << 8) | 32'(n);
    p.rob_addr    = 4'(src + n);
    return p;
  endfunction

  task automatic drive(input int src, input cdb_pkt_t p);
    src_wb[src]       = p.wb;
    src_rob_addr[src] = p.rob_addr;
  endtask

  task automatic idle(input int src);
    src_wb[src]       = {$bits(wb_bus_t){1'b0}};
    src_rob_addr[src] = 4'd0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) idle(i);
  endtask

  // Every valid broadcast must match the oldest outstanding expectation.
  task automatic monitor();
    cdb_pkt_t obs;
    cdb_pkt_t e;
    obs = {cdb, cdb_rob_addr};
    if (cdb.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bcast", 64'(obs), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcast", 64'(obs), 64'(e));
      end
    end else if (cdb.valid !== 1'b0) begin
      check("cdb_valid_known", 64'(cdb.valid), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    exp_q.delete();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Sources a<b hold valid for n_edges edges starting with rr_ptr=0;
  // broadcasts alternate a,b and each queue fills on alternate cycles.
  task automatic pair_stream(input int a, input int b, input int n_edges);
    int       na;
    int       nb;
    logic     ra;
    logic     rb;
    cdb_pkt_t p;
    na = 0;
    nb = 0;
    ra = 1'b1;
    rb = 1'b1;
    for (int k = 0; k < n_edges; k++) begin
      p = mk(a, na);
      drive(a, p);
      if (ra) begin
        exp_q.push_back(p);
        na++;
      end
      p = mk(b, nb);
      drive(b, p);
      if (rb) begin
        exp_q.push_back(p);
        nb++;
      end
      tick();
      ra = (k < 2) || (k % 2 == 1);
      rb = (k % 2 == 0);
      check($sformatf("ready%0d_k%0d", a, k), 64'(src_ready[a]), 64'(ra));
      check($sformatf("ready%0d_k%0d", b, k), 64'(src_ready[b]), 64'(rb));
    end
    idle(a);
    idle(b);
  endtask

  initial begin
    cdb_pkt_t p;
    cdb_pkt_t q;

    // Reset state
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    #3;
    check("rst_cdb_valid", 64'(cdb.valid), 64'd0);
    check("rst_cdb_all", 64'(cdb), 64'd0);
    check("rst_rob", 64'(cdb_rob_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(src_ready), 64'hF);

    // Single push: visible only after the second edge, then gone
    p.wb.valid    = 1'b1;
    p.wb.rd_addr  = 5'd5;
    p.wb.rd_paddr = 6'd12;
    p.wb.rd_data  = 32'hDEAD_BEEF;
    p.rob_addr    = 4'd3;
    drive(0, p);
    exp_q.push_back(p);
    tick();
    idle(0);
    check("single_not_yet", 64'(cdb.valid), 64'd0);
    tick();
    check("single_valid", 64'(cdb.valid), 64'd1);
    check("single_rob", 64'(cdb_rob_addr), 64'd3);
    tick();
    check("single_gone", 64'(cdb.valid), 64'd0);
    drain("single_drain");

    // Fairness: four simultaneous pushes broadcast in index order
    do_reset();
    for (int s = 0; s < N; s++) begin
      p = mk(s, 0);
      p.wb.rd_data = 32'(16 * (s + 1));
      drive(s, p);
      exp_q.push_back(p);
    end
    tick();
    idle_all();
    check("fair_not_yet", 64'(cdb.valid), 64'd0);
    for (int s = 0; s < N; s++) begin
      tick();
      check($sformatf("fair_valid%0d", s), 64'(cdb.valid), 64'd1);
    end
    tick();
    check("fair_idle", 64'(cdb.valid), 64'd0);
    // rr_ptr back at 0: src0 must beat src1
    p = mk(1, 5);
    q = mk(0, 6);
    drive(1, p);
    drive(0, q);
    exp_q.push_back(q);
    exp_q.push_back(p);
    tick();
    idle_all();
    drain("fair_drain");

    // Rotation between sources 1 and 3
    do_reset();
    pair_stream(1, 3, 8);
    drain("rot_drain");

    // Backpressure and pointer wrap: src2 six packets against src0
    do_reset();
    pair_stream(0, 2, 10);
    drain("wrap_drain");

    // Flush: queued packets and the flush-cycle push never broadcast
    do_reset();
    drive(0, mk(0, 7));
    drive(1, mk(1, 7));
    drive(2, mk(2, 7));
    tick();
    idle_all();
    flush = 1'b1;
    drive(3, mk(3, 9));
    tick();
    flush = 1'b0;
    idle(3);
    check("flush_cdb_valid", 64'(cdb.valid), 64'd0);
    check("flush_ready", 64'(src_ready), 64'hF);
    for (int i = 0; i < 5; i++) tick();
    p = mk(1, 11);
    q = mk(0, 12);
    drive(1, p);
    drive(0, q);
    exp_q.push_back(q);
    exp_q.push_back(p);
    tick();
    idle_all();
    drain("flush_drain");

    // Asynchronous reset mid-stream
    do_reset();
    for (int s = 0; s < N; s++) begin
      p = mk(s, 4);
      drive(s, p);
      exp_q.push_back(p);
    end
    tick();
    idle_all();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cdb_valid", 64'(cdb.valid), 64'd0);
    check("arst_rob", 64'(cdb_rob_addr), 64'd0);
    check("arst_ready", 64'(src_ready), 64'hF);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    p = mk(2, 13);
    drive(2, p);
    exp_q.push_back(p);
    tick();
    idle(2);
    drain("arst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
